// File: rtl/ddr_model_fifo_sync_if.sv
// Bus bundle for the DDR3 model read-return FIFO: push side (din/wr_en),
// pop side (rd_en/dout) and the four status flags.
interface ddr_model_fifo_sync_if #(
  parameter int pDATA_WIDTH = 64
);
  logic [pDATA_WIDTH-1:0] din;
  logic                   wr_en;
  logic                   rd_en;
  logic [pDATA_WIDTH-1:0] dout;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  logic                   underflow;

  // master = producer/consumer driving requests; slave = the FIFO itself
  modport master (
    output din, wr_en, rd_en,
    input  dout, full, empty, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, empty, overflow, underflow
  );
endinterface

// File: rtl/ddr_model_fifo_sync.sv
// Single-clock standard-mode FIFO used as the DDR3 model read-return queue.
// Define DDR_FIFO_STICKY_ERR_EN to make overflow/underflow sticky until rst.
module ddr_model_fifo_sync #(
  parameter int pDATA_WIDTH = 64,
  parameter int pDEPTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  ddr_model_fifo_sync_if.slave   bus
);
  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(pDEPTH);

  // Request semantics: wr_en is accepted on an edge only when full is low,
  // rd_en only when empty is low; a rejected request leaves all state alone
  // and raises its error flag after that edge. dout updates only on an
  // accepted read.
  logic [pDATA_WIDTH-1:0] mem [pDEPTH];

  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [pDATA_WIDTH-1:0] dout_q;
  logic                   full_q, empty_q;
  logic                   ovf_q, unf_q;
  logic                   ovf_d, unf_d;

  logic wr_accept, rd_accept, wr_reject, rd_reject;

  assign wr_accept = bus.wr_en && !full_q;
  assign rd_accept = bus.rd_en && !empty_q;
  assign wr_reject = bus.wr_en && full_q;
  assign rd_reject = bus.rd_en && empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_accept && !rd_accept)      count_d = count_q + 1'b1;
    else if (rd_accept && !wr_accept) count_d = count_q - 1'b1;
`ifdef DDR_FIFO_STICKY_ERR_EN
    ovf_d = ovf_q | wr_reject;
    unf_d = unf_q | rd_reject;
`else
    ovf_d = wr_reject;
    unf_d = rd_reject;
`endif
  end

  // Storage is intentionally not reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q[AW-1:0]] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      if (rd_accept) dout_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  assign bus.dout      = dout_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_ddr_model_fifo_sync.sv
// Directed bench for ddr_model_fifo_sync: reset, ordering, fill/overflow,
// underflow, simultaneous push/pop across wrap, and async reset mid-stream.
module tb_ddr_model_fifo_sync;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

`ifdef DDR_FIFO_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  ddr_model_fifo_sync_if #(.pDATA_WIDTH(64)) bus ();

  ddr_model_fifo_sync #(.pDATA_WIDTH(64), .pDEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.din = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    // reset
    tick(); tick(); tick();
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_dout", bus.dout, 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_unf", 64'(bus.underflow), 64'd0);
    rst = 1'b0;
    tick();

    // basic order
    bus.wr_en = 1'b1;
    bus.din = 64'h1111_2222_3333_4444;
    tick();
    chk("basic_empty_fall", 64'(bus.empty), 64'd0);
    bus.din = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    chk("basic_rd0", bus.dout, 64'h1111_2222_3333_4444);
    chk("basic_not_empty", 64'(bus.empty), 64'd0);
    tick();
    chk("basic_rd1", bus.dout, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("basic_empty", 64'(bus.empty), 64'd1);
    bus.rd_en = 1'b0;
    tick();
    chk("basic_hold", bus.dout, 64'hAAAA_BBBB_CCCC_DDDD);

    // fill to full, then one rejected write
    bus.wr_en = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      bus.din = 64'(i);
      tick();
      if (i == 30) chk("fill_not_full_31", 64'(bus.full), 64'd0);
      if (i == 31) begin
        chk("fill_full_32", 64'(bus.full), 64'd1);
        chk("fill_no_ovf_yet", 64'(bus.overflow), 64'd0);
      end
    end
    chk("ovf_pulse", 64'(bus.overflow), 64'd1);
    chk("ovf_still_full", 64'(bus.full), 64'd1);
    bus.wr_en = 1'b0;
    tick();
    chk("ovf_after", 64'(bus.overflow), 64'(STICKY));

    // full: write stays rejected even with a simultaneous accepted read
    bus.wr_en = 1'b1;
    bus.din = 64'd99;
    bus.rd_en = 1'b1;
    tick();
    chk("full_rw_dout", bus.dout, 64'd0);
    chk("full_rw_ovf", 64'(bus.overflow), 64'd1);
    chk("full_rw_full_fall", 64'(bus.full), 64'd0);
    bus.wr_en = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("drain", bus.dout, 64'(i));
    end
    chk("drain_empty", 64'(bus.empty), 64'd1);

    // underflow: read while empty
    tick();
    chk("unf_pulse", 64'(bus.underflow), 64'd1);
    chk("unf_dout_hold", bus.dout, 64'd31);
    bus.rd_en = 1'b0;
    tick();
    chk("unf_after", 64'(bus.underflow), 64'(STICKY));
    chk("unf_dout_hold2", bus.dout, 64'd31);

    // move pointers near the top so the simultaneous phase wraps
    bus.wr_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      bus.din = 64'(200 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("preburst_last", bus.dout, 64'd224);
    bus.rd_en = 1'b0;

    // simultaneous push/pop with 5 queued
    bus.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.din = 64'(100 + i);
      tick();
    end
    bus.rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.din = 64'(105 + k);
      tick();
      chk("simul_dout", bus.dout, 64'(100 + k));
      chk("simul_full", 64'(bus.full), 64'd0);
      chk("simul_empty", 64'(bus.empty), 64'd0);
    end
    bus.rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.din = 64'(115 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    chk("pre_rst_empty", 64'(bus.empty), 64'd0);

    // async reset between edges
    rst = 1'b1;
    #2;
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_full", 64'(bus.full), 64'd0);
    chk("arst_dout", bus.dout, 64'd0);
    chk("arst_ovf", 64'(bus.overflow), 64'd0);
    chk("arst_unf", 64'(bus.underflow), 64'd0);
    #2;
    rst = 1'b0;
    bus.wr_en = 1'b1;
    bus.din = 64'hDEAD_BEEF_0123_4567;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    chk("arst_new_word", bus.dout, 64'hDEAD_BEEF_0123_4567);
    chk("arst_new_empty", 64'(bus.empty), 64'd1);
    bus.rd_en = 1'b0;
    tick();
    chk("arst_new_unf", 64'(bus.underflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
